muldiv_issue_ctrl: RTL and testbench

//  Sequencer between the EX stage and the multi-cycle multiplier/divider units.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_issue_ctrl_if.sv | 56 +++++
 rtl/muldiv_op_decode.sv | 35 +++
 rtl/muldiv_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared definitions for the mul/div issue controller: one-hot op
//             bit positions, op width, FSM state encoding and a one-hot check.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int OP_W = 7;

  // Bit positions inside the one-hot op vector
  localparam int OP_MUL   = 0;
  localparam int OP_MULH  = 1;
  localparam int OP_MULHU = 2;
  localparam int OP_DIV   = 3;
  localparam int OP_DIVU  = 4;
  localparam int OP_MOD   = 5;
  localparam int OP_MODU  = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - OP_W'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_issue_ctrl_if
//  Purpose  : Bundles the EX request/response handshake and the multiplier /
//             divider start/done buses of the mul/div issue controller.
//  Modports : slave  - the controller (drives req_ready, resp_*, busy, unit
//                      start/operand signals)
//             master - EX stage plus the arithmetic units (drives req_*,
//                      flush, resp_ready, unit done/result signals)
//  Revision : 1.0 - initial release
// ============================================================================
interface muldiv_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = muldiv_pkg::OP_W
);
  logic                  req_valid;
  logic                  req_ready;
  logic [OP_W-1:0]       req_op;
  logic [DATA_W-1:0]     req_src1;
  logic [DATA_W-1:0]     req_src2;
  logic                  flush;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_result;
  logic                  busy;
  logic                  mul_start;
  logic                  mul_signed;
  logic [DATA_W-1:0]     mul_x;
  logic [DATA_W-1:0]     mul_y;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_result;
  logic                  div_start;
  logic                  div_signed;
  logic [DATA_W-1:0]     div_x;
  logic [DATA_W-1:0]     div_y;
  logic                  div_done;
  logic [DATA_W-1:0]     div_s;
  logic [DATA_W-1:0]     div_r;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, resp_ready,
           mul_done, mul_result, div_done, div_s, div_r,
    output req_ready, resp_valid, resp_result, busy,
           mul_start, mul_signed, mul_x, mul_y,
           div_start, div_signed, div_x, div_y
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, resp_ready,
           mul_done, mul_result, div_done, div_s, div_r,
    input  req_ready, resp_valid, resp_result, busy,
           mul_start, mul_signed, mul_x, mul_y,
           div_start, div_signed, div_x, div_y
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_op_decode
//  Purpose  : Combinational decode of the one-hot mul/div op.
//  Ports    : op_i       - one-hot op
//             is_mul_o   - mul/mulh/mulhu
//             is_div_o   - div/divu/mod/modu
//             signed_o   - signed variant (mul, mulh, div, mod)
//             hi_sel_o   - take upper product half (mulh, mulhu)
//             rem_sel_o  - take remainder (mod, modu)
//             illegal_o  - op is zero or has more than one bit set
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_op_decode #(
  parameter int OP_W = muldiv_pkg::OP_W
) (
  input  logic [OP_W-1:0] op_i,
  output logic            is_mul_o,
  output logic            is_div_o,
  output logic            signed_o,
  output logic            hi_sel_o,
  output logic            rem_sel_o,
  output logic            illegal_o
);
  import muldiv_pkg::*;

  assign is_mul_o  = op_i[OP_MUL] | op_i[OP_MULH] | op_i[OP_MULHU];
  assign is_div_o  = op_i[OP_DIV] | op_i[OP_DIVU] | op_i[OP_MOD] | op_i[OP_MODU];
  assign signed_o  = op_i[OP_MUL] | op_i[OP_MULH] | op_i[OP_DIV] | op_i[OP_MOD];
  assign hi_sel_o  = op_i[OP_MULH] | op_i[OP_MULHU];
  assign rem_sel_o = op_i[OP_MOD] | op_i[OP_MODU];
  assign illegal_o = ~is_onehot(op_i);

endmodule
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_issue_ctrl
//  Purpose  : Sequences one mul/div op from EX to the multi-cycle multiplier
//             or divider: latches operands, pulses the unit start for one
//             cycle, waits for done, and returns a registered result over a
//             valid/ready handshake. A flush discards the op; a unit already
//             started is drained rather than aborted.
//  Ports    : clk     - clock
//             resetn  - asynchronous active-low reset
//             bus     - muldiv_issue_ctrl_if.slave (request, response, busy,
//                       multiplier and divider buses)
//  Config   : DIV_ZERO_FAST_EN - when defined, a div-class op with src2 == 0
//             bypasses the divider and answers one cycle after accept
//             (quotient all ones, remainder = src1).
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = muldiv_pkg::OP_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  muldiv_issue_ctrl_if.slave   bus
);
  import muldiv_pkg::*;

  state_e              state_q, state_d;
  logic                is_mul_q, is_mul_d;
  logic                is_div_q, is_div_d;
  logic                signed_q, signed_d;
  logic                hi_sel_q, hi_sel_d;
  logic                rem_sel_q, rem_sel_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   src2_q, src2_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                w_dec_is_mul, w_dec_is_div, w_dec_signed;
  logic                w_dec_hi_sel, w_dec_rem_sel, w_dec_illegal;
  logic                w_accept;
  logic                w_sel_done;
  logic [DATA_W-1:0]   w_sel_result;
  logic                w_fast_div0;
  logic [DATA_W-1:0]   w_fast_result;

  muldiv_op_decode #(.OP_W(OP_W)) u_decode (
    .op_i      (bus.req_op),
    .is_mul_o  (w_dec_is_mul),
    .is_div_o  (w_dec_is_div),
    .signed_o  (w_dec_signed),
    .hi_sel_o  (w_dec_hi_sel),
    .rem_sel_o (w_dec_rem_sel),
    .illegal_o (w_dec_illegal)
  );

  assign w_accept = bus.req_valid & bus.req_ready;

  // done and result of whichever unit the held op targets
  assign w_sel_done   = is_mul_q ? bus.mul_done : bus.div_done;
  assign w_sel_result = is_mul_q
                      ? (hi_sel_q ? bus.mul_result[2*DATA_W-1:DATA_W]
                                  : bus.mul_result[DATA_W-1:0])
                      : (rem_sel_q ? bus.div_r : bus.div_s);

`ifdef DIV_ZERO_FAST_EN
  assign w_fast_div0   = w_dec_is_div & ~w_dec_illegal & (bus.req_src2 == '0);
  assign w_fast_result = w_dec_rem_sel ? bus.req_src1 : '1;
`else
  assign w_fast_div0   = 1'b0;
  assign w_fast_result = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      is_mul_q  <= 1'b0;
      is_div_q  <= 1'b0;
      signed_q  <= 1'b0;
      hi_sel_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_mul_q  <= is_mul_d;
      is_div_q  <= is_div_d;
      signed_q  <= signed_d;
      hi_sel_q  <= hi_sel_d;
      rem_sel_q <= rem_sel_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_mul_d  = is_mul_q;
    is_div_d  = is_div_q;
    signed_d  = signed_q;
    hi_sel_d  = hi_sel_q;
    rem_sel_d = rem_sel_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          // An illegal op never reaches a unit, so both unit flags stay clear
          is_mul_d  = w_dec_is_mul & ~w_dec_illegal;
          is_div_d  = w_dec_is_div & ~w_dec_illegal;
          signed_d  = w_dec_signed;
          hi_sel_d  = w_dec_hi_sel;
          rem_sel_d = w_dec_rem_sel;
          src1_d    = bus.req_src1;
          src2_d    = bus.req_src2;
          if (w_dec_illegal) begin
            result_d = '0;
            state_d  = ST_RESP;
          end else if (w_fast_div0) begin
            result_d = w_fast_result;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
          end
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (bus.flush) begin
          // A done arriving with the flush completes the drain immediately
          state_d = w_sel_done ? ST_IDLE : ST_DRAIN;
        end else if (w_sel_done) begin
          result_d = w_sel_result;
          state_d  = ST_RESP;
        end else begin
          state_d  = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (bus.flush || bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (w_sel_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == ST_IDLE) & ~bus.flush;
  assign bus.resp_valid  = (state_q == ST_RESP);
  assign bus.resp_result = result_q;
  assign bus.busy        = (state_q != ST_IDLE);

  // Start pulses follow the state, so a flush during ISSUE still launches
  assign bus.mul_start   = (state_q == ST_ISSUE) & is_mul_q;
  assign bus.mul_signed  = is_mul_q & signed_q;
  assign bus.mul_x       = src1_q;
  assign bus.mul_y       = src2_q;

  assign bus.div_start   = (state_q == ST_ISSUE) & is_div_q;
  assign bus.div_signed  = is_div_q & signed_q;
  assign bus.div_x       = src1_q;
  assign bus.div_y       = src2_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_issue_ctrl
//  Purpose  : Directed self-checking bench for muldiv_issue_ctrl. The bench
//             plays the EX stage and both arithmetic units, driving done and
//             result values by hand.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  muldiv_issue_ctrl_if #(.DATA_W(32), .OP_W(7)) bus ();

  muldiv_issue_ctrl #(.DATA_W(32), .OP_W(7)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the ISSUE cycle
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    #1;
    chk("req_ready_at_accept", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    step();
    chk("busy_after_resp", 64'(bus.busy), 64'd0);
    chk("resp_valid_after_resp", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_src1   = '0;
    bus.req_src2   = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    bus.div_done   = 1'b0;
    bus.div_s      = '0;
    bus.div_r      = '0;
    resetn         = 1'b0;
    step();
    step();

    // reset state
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
    chk("rst_div_start", 64'(bus.div_start), 64'd0);
    chk("rst_result", 64'(bus.resp_result), 64'd0);
    chk("rst_mul_x", 64'(bus.mul_x), 64'd0);
    chk("rst_div_y", 64'(bus.div_y), 64'd0);
    resetn = 1'b1;
    step();

    // mul -3*5, done 4 cycles after start
    issue(7'b0000001, 32'hFFFF_FFFD, 32'd5);
    chk("mul_start_pulse", 64'(bus.mul_start), 64'd1);
    chk("mul_no_div_start", 64'(bus.div_start), 64'd0);
    chk("mul_signed", 64'(bus.mul_signed), 64'd1);
    chk("mul_x", 64'(bus.mul_x), 64'h0000_0000_FFFF_FFFD);
    chk("mul_y", 64'(bus.mul_y), 64'd5);
    chk("mul_busy", 64'(bus.busy), 64'd1);
    chk("mul_req_ready", 64'(bus.req_ready), 64'd0);
    step();
    chk("mul_start_one_cycle", 64'(bus.mul_start), 64'd0);
    step();
    step();
    chk("mul_no_early_resp", 64'(bus.resp_valid), 64'd0);
    step();
    bus.mul_done   = 1'b1;
    bus.mul_result = 64'hFFFF_FFFF_FFFF_FFF1;
    step();
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    chk("mul_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("mul_result", 64'(bus.resp_result), 64'h0000_0000_FFFF_FFF1);
    finish_resp();

    // mulhu 0xFFFFFFFF*2, done in the ISSUE cycle
    issue(7'b0000100, 32'hFFFF_FFFF, 32'd2);
    chk("mulhu_signed", 64'(bus.mul_signed), 64'd0);
    chk("mulhu_start", 64'(bus.mul_start), 64'd1);
    bus.mul_done   = 1'b1;
    bus.mul_result = 64'h0000_0001_FFFF_FFFE;
    step();
    bus.mul_done   = 1'b0;
    chk("mulhu_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("mulhu_result", 64'(bus.resp_result), 64'd1);
    finish_resp();

    // mod -7,2 with resp_ready low for 5 cycles
    bus.resp_ready = 1'b0;
    issue(7'b0100000, 32'hFFFF_FFF9, 32'd2);
    chk("mod_div_start", 64'(bus.div_start), 64'd1);
    chk("mod_div_signed", 64'(bus.div_signed), 64'd1);
    chk("mod_no_mul_start", 64'(bus.mul_start), 64'd0);
    step();
    bus.div_done = 1'b1;
    bus.div_s    = 32'hFFFF_FFFD;
    bus.div_r    = 32'hFFFF_FFFF;
    step();
    bus.div_done = 1'b0;
    bus.div_s    = '0;
    bus.div_r    = '0;
    for (int i = 0; i < 5; i++) begin
      chk("mod_resp_valid_hold", 64'(bus.resp_valid), 64'd1);
      chk("mod_result_hold", 64'(bus.resp_result), 64'h0000_0000_FFFF_FFFF);
      chk("mod_req_ready_low", 64'(bus.req_ready), 64'd0);
      step();
    end
    finish_resp();

    // divu 10,0
    issue(7'b0010000, 32'd10, 32'd0);
`ifdef DIV_ZERO_FAST_EN
    chk("divz_fast_resp", 64'(bus.resp_valid), 64'd1);
    chk("divz_fast_no_start", 64'(bus.div_start), 64'd0);
    chk("divz_fast_result", 64'(bus.resp_result), 64'h0000_0000_FFFF_FFFF);
`else
    chk("divz_start", 64'(bus.div_start), 64'd1);
    chk("divz_no_resp", 64'(bus.resp_valid), 64'd0);
    bus.div_done = 1'b1;
    bus.div_s    = 32'hFFFF_FFFF;
    bus.div_r    = 32'd10;
    step();
    bus.div_done = 1'b0;
    chk("divz_resp", 64'(bus.resp_valid), 64'd1);
    chk("divz_result", 64'(bus.resp_result), 64'h0000_0000_FFFF_FFFF);
`endif
    finish_resp();

    // flush in WAIT of div, done three cycles later
    issue(7'b0001000, 32'd100, 32'd7);
    chk("fl_div_start", 64'(bus.div_start), 64'd1);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_drain_busy", 64'(bus.busy), 64'd1);
    chk("fl_drain_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("fl_drain_not_ready", 64'(bus.req_ready), 64'd0);
    step();
    chk("fl_drain_no_resp2", 64'(bus.resp_valid), 64'd0);
    step();
    bus.div_done = 1'b1;
    bus.div_s    = 32'd14;
    step();
    bus.div_done = 1'b0;
    chk("fl_busy_drop", 64'(bus.busy), 64'd0);
    chk("fl_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("fl_ready_again", 64'(bus.req_ready), 64'd1);
    issue(7'b0000001, 32'd6, 32'd7);
    chk("fl_next_start", 64'(bus.mul_start), 64'd1);
    bus.mul_done   = 1'b1;
    bus.mul_result = 64'd42;
    step();
    bus.mul_done   = 1'b0;
    chk("fl_next_result", 64'(bus.resp_result), 64'd42);
    finish_resp();

    // flush together with done in ISSUE: result discarded
    issue(7'b0000001, 32'd3, 32'd3);
    bus.flush      = 1'b1;
    bus.mul_done   = 1'b1;
    bus.mul_result = 64'd9;
    step();
    bus.flush      = 1'b0;
    bus.mul_done   = 1'b0;
    chk("fldone_busy", 64'(bus.busy), 64'd0);
    chk("fldone_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("fldone_result_kept", 64'(bus.resp_result), 64'd42);

    // illegal op: no start, answer 0 next cycle
    issue(7'b0000011, 32'd5, 32'd5);
    chk("ill_no_mul_start", 64'(bus.mul_start), 64'd0);
    chk("ill_no_div_start", 64'(bus.div_start), 64'd0);
    chk("ill_resp", 64'(bus.resp_valid), 64'd1);
    chk("ill_result", 64'(bus.resp_result), 64'd0);
    finish_resp();

    // flush in IDLE blocks accept
    bus.req_valid = 1'b1;
    bus.req_op    = 7'b0000001;
    bus.flush     = 1'b1;
    #1;
    chk("idle_flush_not_ready", 64'(bus.req_ready), 64'd0);
    step();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("idle_flush_busy", 64'(bus.busy), 64'd0);
    chk("idle_flush_no_start", 64'(bus.mul_start), 64'd0);

    // flush in RESP drops resp_valid
    bus.resp_ready = 1'b0;
    issue(7'b0000010, 32'h8000_0000, 32'd2);
    bus.mul_done   = 1'b1;
    bus.mul_result = 64'hFFFF_FFFF_0000_0000;
    step();
    bus.mul_done   = 1'b0;
    chk("mulh_resp", 64'(bus.resp_valid), 64'd1);
    chk("mulh_result", 64'(bus.resp_result), 64'h0000_0000_FFFF_FFFF);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("resp_flush_valid", 64'(bus.resp_valid), 64'd0);
    chk("resp_flush_busy", 64'(bus.busy), 64'd0);
    bus.resp_ready = 1'b1;

    // reset in WAIT, then stale done ignored
    issue(7'b1000000, 32'd9, 32'd4);
    chk("modu_unsigned", 64'(bus.div_signed), 64'd0);
    step();
    resetn = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_div_start", 64'(bus.div_start), 64'd0);
    chk("arst_div_x", 64'(bus.div_x), 64'd0);
    chk("arst_result", 64'(bus.resp_result), 64'd0);
    step();
    resetn = 1'b1;
    #1;
    chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
    bus.div_done = 1'b1;
    bus.div_r    = 32'd1;
    step();
    bus.div_done = 1'b0;
    chk("stale_done_busy", 64'(bus.busy), 64'd0);
    chk("stale_done_resp", 64'(bus.resp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
